// File: rtl/drive_mode_controller_if.sv
// Run-mode bus between the line-follower sequencer and its surroundings:
// start/stop/sensor/PID inputs in, wheel speed codes and PID control out.
interface drive_mode_controller_if;
  logic              start;
  logic              stop;
  logic [3:0]        sensor;
  logic signed [10:0] pid_output;
  logic [7:0]        servo_l;
  logic [7:0]        servo_r;
  logic              pid_en;
  logic              pid_clr;
  logic [2:0]        mode;

  modport master (
    output start, stop, sensor, pid_output,
    input  servo_l, servo_r, pid_en, pid_clr, mode
  );

  modport slave (
    input  start, stop, sensor, pid_output,
    output servo_l, servo_r, pid_en, pid_clr, mode
  );
endinterface

// File: rtl/drive_mode_controller.sv
// Line-follower run-mode sequencer: IDLE -> ARM -> FOLLOW, timed pivot SEARCH
// when the line is lost, HALT when the search gives up.
module drive_mode_controller #(
  parameter int TICK_DIV     = 100000,
  parameter int ARM_TICKS    = 500,
  parameter int LOST_TICKS   = 50,
  parameter int SEARCH_TICKS = 3000,
  parameter int BASE_SPD     = 40,
  parameter int SEARCH_SPD   = 30,
  parameter int CORR_SHIFT   = 2
) (
  input logic clk,
  input logic rst,
  drive_mode_controller_if.slave bus
);

  localparam int PW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
  localparam int AW = (ARM_TICKS > 1)    ? $clog2(ARM_TICKS)    : 1;
  localparam int LW = (LOST_TICKS > 1)   ? $clog2(LOST_TICKS)   : 1;
  localparam int SW = (SEARCH_TICKS > 1) ? $clog2(SEARCH_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE   = PW'(1);
  localparam logic [AW-1:0] ARM_LAST    = AW'(ARM_TICKS - 1);
  localparam logic [AW-1:0] ARM_ONE     = AW'(1);
  localparam logic [LW-1:0] LOST_LAST   = LW'(LOST_TICKS - 1);
  localparam logic [LW-1:0] LOST_ONE    = LW'(1);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TICKS - 1);
  localparam logic [SW-1:0] SEARCH_ONE  = SW'(1);

  localparam logic signed [12:0] FWD_BASE = 13'(128 + BASE_SPD);
  localparam logic [7:0] SERVO_STOP = 8'd128;
  localparam logic [7:0] PIVOT_REV  = 8'(128 - SEARCH_SPD);
  localparam logic [7:0] PIVOT_FWD  = 8'(128 + SEARCH_SPD);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_FOLLOW = 3'd2,
    ST_SEARCH = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Clamp a signed mix result into the 0..255 speed code range.
  function automatic logic [7:0] sat_u8(input logic signed [12:0] v);
    logic [7:0] res;
    if (v < 13'sd0) begin
      res = 8'd0;
    end else if (v > 13'sd255) begin
      res = 8'd255;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

  logic [1:0]    start_sync_r;
  logic [1:0]    stop_sync_r;
  logic [3:0]    sensor_meta_r;
  logic [3:0]    sensor_sync_r;
  logic          start_prev_r;
  logic [PW-1:0] presc_r;
  logic [AW-1:0] arm_cnt_r;
  logic [LW-1:0] lost_cnt_r;
  logic [SW-1:0] search_cnt_r;
  logic          last_dir_r;
  state_t        state_r;
  logic [7:0]    servo_l_r;
  logic [7:0]    servo_r_r;
  logic          pid_en_r;
  logic          pid_clr_r;

  logic              start_rise_s;
  logic              stop_s;
  logic              line_seen_s;
  logic              tick_s;
  state_t            state_nxt_s;
  logic [AW-1:0]     arm_cnt_nxt_s;
  logic [LW-1:0]     lost_cnt_nxt_s;
  logic [SW-1:0]     search_cnt_nxt_s;
  logic              last_dir_nxt_s;
  logic signed [12:0] pid_ext_s;
  logic signed [12:0] corr_s;
  logic signed [12:0] mix_l_s;
  logic signed [12:0] mix_r_s;
  logic [7:0]        servo_l_nxt_s;
  logic [7:0]        servo_r_nxt_s;
  logic              pid_en_nxt_s;
  logic              pid_clr_nxt_s;

  assign start_rise_s = start_sync_r[1] & ~start_prev_r;
  assign stop_s       = stop_sync_r[1];
  assign line_seen_s  = (sensor_sync_r != 4'b0000);
  assign tick_s       = (presc_r == PRESC_MAX);

  assign pid_ext_s = {{2{bus.pid_output[10]}}, bus.pid_output};
  assign corr_s    = pid_ext_s >>> CORR_SHIFT;
  assign mix_l_s   = FWD_BASE + corr_s;
  assign mix_r_s   = FWD_BASE - corr_s;

  // Two-flop synchronizers for the asynchronous pins plus the start edge register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync_r  <= 2'b00;
      stop_sync_r   <= 2'b00;
      sensor_meta_r <= 4'b0000;
      sensor_sync_r <= 4'b0000;
      start_prev_r  <= 1'b0;
    end else begin
      start_sync_r  <= {start_sync_r[0], bus.start};
      stop_sync_r   <= {stop_sync_r[0], bus.stop};
      sensor_meta_r <= bus.sensor;
      sensor_sync_r <= sensor_meta_r;
      start_prev_r  <= start_sync_r[1];
    end
  end

  // Free-running control-tick prescaler; never realigned on state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= {PW{1'b0}};
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  // Side where the line was last seen; ambiguous or empty readings hold it.
  always_comb begin
    last_dir_nxt_s = last_dir_r;
    if ((sensor_sync_r[3:2] != 2'b00) && (sensor_sync_r[1:0] == 2'b00)) begin
      last_dir_nxt_s = DIR_LEFT;
    end else if ((sensor_sync_r[1:0] != 2'b00) && (sensor_sync_r[3:2] == 2'b00)) begin
      last_dir_nxt_s = DIR_RIGHT;
    end else begin
      last_dir_nxt_s = last_dir_r;
    end
  end

  // Next-state and tick counters; stop dominates every transition.
  always_comb begin
    state_nxt_s      = state_r;
    arm_cnt_nxt_s    = arm_cnt_r;
    lost_cnt_nxt_s   = lost_cnt_r;
    search_cnt_nxt_s = search_cnt_r;
    if (stop_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start_rise_s) begin
            state_nxt_s = ST_ARM;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_ARM: begin
          if (tick_s && (arm_cnt_r == ARM_LAST)) begin
            state_nxt_s = ST_FOLLOW;
          end else if (tick_s) begin
            arm_cnt_nxt_s = arm_cnt_r + ARM_ONE;
          end else begin
            arm_cnt_nxt_s = arm_cnt_r;
          end
        end
        ST_FOLLOW: begin
          if (line_seen_s) begin
            lost_cnt_nxt_s = {LW{1'b0}};
          end else if (tick_s && (lost_cnt_r == LOST_LAST)) begin
            state_nxt_s = ST_SEARCH;
          end else if (tick_s) begin
            lost_cnt_nxt_s = lost_cnt_r + LOST_ONE;
          end else begin
            lost_cnt_nxt_s = lost_cnt_r;
          end
        end
        ST_SEARCH: begin
          // Reacquiring the line wins over a timeout tick in the same cycle.
          if (line_seen_s) begin
            state_nxt_s = ST_FOLLOW;
          end else if (tick_s && (search_cnt_r == SEARCH_LAST)) begin
            state_nxt_s = ST_HALT;
          end else if (tick_s) begin
            search_cnt_nxt_s = search_cnt_r + SEARCH_ONE;
          end else begin
            search_cnt_nxt_s = search_cnt_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
    if (state_nxt_s != state_r) begin
      arm_cnt_nxt_s    = {AW{1'b0}};
      lost_cnt_nxt_s   = {LW{1'b0}};
      search_cnt_nxt_s = {SW{1'b0}};
    end else begin
      arm_cnt_nxt_s    = arm_cnt_nxt_s;
    end
  end

  // Output values for the upcoming state so mode and servos change together.
  always_comb begin
    servo_l_nxt_s = SERVO_STOP;
    servo_r_nxt_s = SERVO_STOP;
    pid_en_nxt_s  = (state_nxt_s == ST_FOLLOW);
    pid_clr_nxt_s = (state_nxt_s == ST_FOLLOW) && (state_r != ST_FOLLOW);
    case (state_nxt_s)
      ST_FOLLOW: begin
        servo_l_nxt_s = sat_u8(mix_l_s);
        servo_r_nxt_s = sat_u8(mix_r_s);
      end
      ST_SEARCH: begin
        if (last_dir_r == DIR_LEFT) begin
          servo_l_nxt_s = PIVOT_REV;
          servo_r_nxt_s = PIVOT_FWD;
        end else begin
          servo_l_nxt_s = PIVOT_FWD;
          servo_r_nxt_s = PIVOT_REV;
        end
      end
      default: begin
        servo_l_nxt_s = SERVO_STOP;
        servo_r_nxt_s = SERVO_STOP;
      end
    endcase
  end

  // State, counters, direction memory and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      arm_cnt_r    <= {AW{1'b0}};
      lost_cnt_r   <= {LW{1'b0}};
      search_cnt_r <= {SW{1'b0}};
      last_dir_r   <= DIR_LEFT;
      servo_l_r    <= SERVO_STOP;
      servo_r_r    <= SERVO_STOP;
      pid_en_r     <= 1'b0;
      pid_clr_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      arm_cnt_r    <= arm_cnt_nxt_s;
      lost_cnt_r   <= lost_cnt_nxt_s;
      search_cnt_r <= search_cnt_nxt_s;
      last_dir_r   <= last_dir_nxt_s;
      servo_l_r    <= servo_l_nxt_s;
      servo_r_r    <= servo_r_nxt_s;
      pid_en_r     <= pid_en_nxt_s;
      pid_clr_r    <= pid_clr_nxt_s;
    end
  end

  assign bus.mode    = state_r;
  assign bus.servo_l = servo_l_r;
  assign bus.servo_r = servo_r_r;
  assign bus.pid_en  = pid_en_r;
  assign bus.pid_clr = pid_clr_r;

endmodule

// File: tb/tb_drive_mode_controller.sv
// Directed bench for drive_mode_controller with a 4-cycle tick; the tick edge
// is every 4th clk edge counted from reset release.
module tb_drive_mode_controller;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  drive_mode_controller_if bus();

  drive_mode_controller #(
    .TICK_DIV(4), .ARM_TICKS(2), .LOST_TICKS(3), .SEARCH_TICKS(5),
    .BASE_SPD(40), .SEARCH_SPD(30), .CORR_SHIFT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_servo(input string tag, input logic [7:0] l, input logic [7:0] r);
    chk({tag, "_l"}, 16'(bus.servo_l), 16'(l));
    chk({tag, "_r"}, 16'(bus.servo_r), 16'(r));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mode"}, 16'(bus.mode), 16'd0);
    chk_servo(tag, 8'd128, 8'd128);
    chk({tag, "_pid_en"}, 16'(bus.pid_en), 16'd0);
    chk({tag, "_pid_clr"}, 16'(bus.pid_clr), 16'd0);
  endtask

  // Advance n clk edges; the bench is parked just after a negedge on return.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_mode(input string tag, input logic [2:0] exp, input int budget);
    int n = 0;
    while (bus.mode !== exp && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 16'(bus.mode), 16'(exp));
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.sensor = 4'b0000;
    bus.pid_output = 11'sd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    cyc = 0;

    // 1: start -> ARM after 3 edges -> FOLLOW on the 2nd tick (edge 8).
    bus.sensor = 4'b0110;
    start_pulse();
    step(1);
    chk("t1_idle_c2", 16'(bus.mode), 16'd0);
    step(1);
    chk("t1_arm_c3", 16'(bus.mode), 16'd1);
    chk_servo("t1_arm_c3", 8'd128, 8'd128);
    step(4);
    chk("t1_arm_c7", 16'(bus.mode), 16'd1);
    chk_servo("t1_arm_c7", 8'd128, 8'd128);
    chk("t1_clr_c7", 16'(bus.pid_clr), 16'd0);
    step(1);
    chk("t1_follow_c8", 16'(bus.mode), 16'd2);
    chk("t1_clr_c8", 16'(bus.pid_clr), 16'd1);
    chk("t1_en_c8", 16'(bus.pid_en), 16'd1);
    chk_servo("t1_follow_c8", 8'd168, 8'd168);
    step(1);
    chk("t1_clr_c9", 16'(bus.pid_clr), 16'd0);
    chk("t1_en_c9", 16'(bus.pid_en), 16'd1);

    // 2: steering mix and saturation.
    bus.pid_output = 11'sd40;
    step(1);
    chk_servo("t2_p40", 8'd178, 8'd158);
    bus.pid_output = 11'sd1023;
    step(1);
    chk_servo("t2_p1023", 8'd255, 8'd0);
    bus.pid_output = 11'h400;
    step(1);
    chk_servo("t2_m1024", 8'd0, 8'd255);
    bus.pid_output = 11'sd0;

    // 3: lost line with a one-cycle glitch, then a real loss to the left.
    step(4);
    bus.sensor = 4'b0000;
    step(8);
    chk("t3_follow_c24", 16'(bus.mode), 16'd2);
    bus.sensor = 4'b0001;
    step(1);
    bus.sensor = 4'b0000;
    step(3);
    chk("t3_glitch_c28", 16'(bus.mode), 16'd2);
    bus.sensor = 4'b1000;
    step(4);
    bus.sensor = 4'b0000;
    step(11);
    chk("t3_follow_c43", 16'(bus.mode), 16'd2);
    step(1);
    chk("t3_search_c44", 16'(bus.mode), 16'd3);
    chk_servo("t3_search_c44", 8'd98, 8'd158);
    chk("t3_en_c44", 16'(bus.pid_en), 16'd0);

    // 4: search timeout on the 5th tick (edge 64), then restart from HALT.
    step(19);
    chk("t4_search_c63", 16'(bus.mode), 16'd3);
    step(1);
    chk("t4_halt_c64", 16'(bus.mode), 16'd4);
    chk_servo("t4_halt_c64", 8'd128, 8'd128);
    chk("t4_en_c64", 16'(bus.pid_en), 16'd0);
    bus.sensor = 4'b0110;
    start_pulse();
    step(1);
    chk("t4_halt_c66", 16'(bus.mode), 16'd4);
    step(1);
    chk("t4_arm_c67", 16'(bus.mode), 16'd1);
    step(5);
    chk("t4_follow_c72", 16'(bus.mode), 16'd2);
    chk("t4_clr_c72", 16'(bus.pid_clr), 16'd1);

    // 5: line reacquired in the same cycle as the search timeout tick.
    bus.sensor = 4'b1000;
    step(4);
    bus.sensor = 4'b0000;
    step(12);
    chk("t5_search_c88", 16'(bus.mode), 16'd3);
    step(17);
    bus.sensor = 4'b0100;
    step(2);
    chk("t5_search_c107", 16'(bus.mode), 16'd3);
    step(1);
    chk("t5_follow_c108", 16'(bus.mode), 16'd2);
    chk("t5_clr_c108", 16'(bus.pid_clr), 16'd1);
    step(1);
    chk("t5_follow_c109", 16'(bus.mode), 16'd2);
    chk("t5_clr_c109", 16'(bus.pid_clr), 16'd0);

    // 6a: stop from FOLLOW while start toggles.
    bus.stop = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    chk("t6_follow_pre", 16'(bus.mode), 16'd2);
    bus.start = 1'b1;
    step(1);
    chk_reset_outputs("t6_follow_stop");
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(2);
    chk("t6_stop_held", 16'(bus.mode), 16'd0);
    bus.start = 1'b0;
    bus.stop = 1'b0;
    step(4);
    chk("t6_released_idle", 16'(bus.mode), 16'd0);

    // 6b: stop from ARM.
    bus.sensor = 4'b0110;
    start_pulse();
    step(2);
    chk("t6_arm", 16'(bus.mode), 16'd1);
    bus.stop = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    chk("t6_arm_pre", 16'(bus.mode), 16'd1);
    step(1);
    chk("t6_arm_stop", 16'(bus.mode), 16'd0);
    chk_servo("t6_arm_stop", 8'd128, 8'd128);
    bus.stop = 1'b0;
    step(4);

    // 6c: stop from SEARCH.
    start_pulse();
    wait_mode("t6_reach_follow", 3'd2, 40);
    bus.sensor = 4'b0000;
    wait_mode("t6_reach_search", 3'd3, 60);
    bus.stop = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(1);
    chk("t6_search_pre", 16'(bus.mode), 16'd3);
    step(1);
    chk("t6_search_stop", 16'(bus.mode), 16'd0);
    chk_servo("t6_search_stop", 8'd128, 8'd128);
    bus.stop = 1'b0;
    step(4);

    // 6d: asynchronous reset mid-SEARCH.
    bus.sensor = 4'b0110;
    start_pulse();
    wait_mode("t6_rst_follow", 3'd2, 40);
    bus.sensor = 4'b0000;
    wait_mode("t6_rst_search", 3'd3, 60);
    step(2);
    chk("t6_rst_pre", 16'(bus.mode), 16'd3);
    chk_servo("t6_rst_pre", 8'd98, 8'd158);
    rst = 1'b0;
    #1;
    chk_reset_outputs("t6_rst_async");
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    step(3);
    chk_reset_outputs("t6_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/drive_mode_controller.md
# drive_mode_controller

Top-level run-mode sequencer for the line follower. It sits between the PID block and the servo-to-PWM stage and owns the robot's behaviour. It holds the wheels at neutral until started, arms the PID, and mixes the PID correction into left/right speed codes while on the line. When the line is lost it runs a timed pivot search toward the side where the line was last seen, and it halts if the search fails.

## Interface
- TICK_DIV, 100000: clk cycles per control tick (1 kHz at 100 MHz).
- ARM_TICKS, 500: ticks spent in ARM before FOLLOW.
- LOST_TICKS, 50: consecutive no-line ticks before SEARCH.
- SEARCH_TICKS, 3000: ticks allowed in SEARCH before HALT.
- BASE_SPD, 40: forward offset from neutral in FOLLOW.
- SEARCH_SPD, 30: pivot offset from neutral in SEARCH.
- CORR_SHIFT, 2: arithmetic right shift applied to pid_output.

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  run request; acts on its rising edge; asynchronous.
- stop  in  1  level stop; asynchronous.
- sensor  in  4  line sensors; bit3 is leftmost, bit0 is rightmost; 1 means line seen; asynchronous.
- pid_output  in  11  signed two's-complement correction; positive steers right.
- servo_l  out  8  left wheel speed code; 128 is stop, 255 is full forward, 0 is full reverse.
- servo_r  out  8  right wheel speed code; same encoding as servo_l.
- pid_en  out  1  high while in FOLLOW.
- pid_clr  out  1  one-cycle pulse that clears the PID integrator/derivative history.
- mode  out  3  current state: IDLE=0, ARM=1, FOLLOW=2, SEARCH=3, HALT=4.

## Operation
- start, stop and sensor each pass through a 2-flop synchronizer. All logic below uses the synchronized values.
- Prescaler counts 0..TICK_DIV-1. `tick` is a one-cycle pulse when it wraps. The ARM, lost and search counters advance only on tick.
- States:
  - IDLE: both servos 128. A start rising edge moves to ARM.
  - ARM: both servos 128. The arm counter clears on entry. The ARM_TICKS-th tick after entry moves to FOLLOW.
  - FOLLOW: corr = pid_output >>> CORR_SHIFT (sign-extended). servo_l = sat(128+BASE_SPD+corr). servo_r = sat(128+BASE_SPD-corr). sat clamps to 0..255 and is computed in at least 12-bit signed. The lost counter increments on each tick with sensor==0. Any cycle with sensor!=0 clears it. The LOST_TICKS-th consecutive no-line tick moves to SEARCH.
  - SEARCH: pivots toward last_dir:
    - LEFT: servo_l=128-SEARCH_SPD, servo_r=128+SEARCH_SPD.
    - RIGHT: the mirror image.
    - The search counter clears on entry. Any sensor!=0 moves to FOLLOW. The SEARCH_TICKS-th tick moves to HALT.
  - HALT: both servos 128. A start rising edge moves to ARM.
- last_dir is updated on every cycle:
  - LEFT when sensor[3:2]!=0 and sensor[1:0]==0.
  - RIGHT when sensor[1:0]!=0 and sensor[3:2]==0.
  - Otherwise it holds.
- pid_clr pulses for one cycle on every entry into FOLLOW, whether from ARM or from SEARCH.
- Priorities:
  - stop=1 forces IDLE from every state and overrides start and all other transitions. stop held keeps IDLE.
  - In SEARCH, sensor!=0 and the timeout tick in the same cycle resolve to FOLLOW.
  - A start edge is ignored in ARM, FOLLOW and SEARCH.

## Timing
- Reset (rst=0, asynchronous) sets:
  - mode=IDLE, servo_l=servo_r=128, pid_en=0, pid_clr=0.
  - All counters and the prescaler to 0.
  - last_dir=LEFT.
  - Synchronizers and the start edge register to 0.
- Reset takes effect immediately in any state, including mid-ARM or mid-SEARCH. The block is operational on the first clk edge after rst deasserts.
- mode, servo_l, servo_r, pid_en and pid_clr are all registered and update on the same edge.
- pin-to-state latency: a start or stop pin change is reflected in mode 3 clk edges later (2 synchronizer edges plus 1 state edge). Sensor changes have the same 3-clk latency.
- In FOLLOW, servos track pid_output with 1 clk latency. pid_output is already synchronous to clk.
- pid_clr is high in the first cycle where mode==FOLLOW. pid_en rises on that same edge.
- The prescaler free-runs and is not realigned on state entry, so the first ARM, lost or search tick may arrive after less than one full tick period.

## Test plan
Parameters for the bench: TICK_DIV=4, ARM_TICKS=2, LOST_TICKS=3, SEARCH_TICKS=5, BASE_SPD=40, SEARCH_SPD=30, CORR_SHIFT=2.

1. Reset, then a start pulse with sensor=0110 -> mode 0, then 1 three clks after the pulse, then 2 on the 2nd tick. pid_clr is high exactly one cycle. servo_l and servo_r are both 128 until FOLLOW.
2. FOLLOW steering:
   - pid_output=+40 -> servo_l=178, servo_r=158.
   - pid_output=+1023 -> servo_l=255, servo_r=0.
   - pid_output=-1024 -> servo_l=0, servo_r=255.
3. FOLLOW, then sensor=1000 followed by 0000 for 3 ticks -> mode=3, servo_l=98, servo_r=158. A sensor glitch to 0001 after 2 of those ticks clears the lost count instead, and the block stays in FOLLOW.
4. SEARCH with sensor held at 0000 for 5 ticks -> mode=4, servos 128/128, pid_en=0. A subsequent start edge -> ARM.
5. SEARCH with sensor going to 0100 in the same cycle as the 5th tick -> mode=2 with a pid_clr pulse; HALT is not entered.
6. stop=1 while start toggles, in each state (ARM, FOLLOW, SEARCH) -> mode=0 and servos 128/128 three clks later, with start ignored. rst=0 asserted mid-SEARCH -> all outputs return to reset values immediately.
